gray_conv_scheduler: RTL and testbench

- Shares one combinational binary-to-Gray converter (`deci_to_gray`, 4-bit) between NREQ requesters.
- Round-robin arbitration, valid/ready handshake on each request port and on the single response port.
- Drives the converter's binary input from a register, captures its Gray output, and returns the result tagged with the requester ID.
- Sits between client blocks and the shared converter instance.

---
 rtl/gray_conv_pkg.sv | 20 ++
 rtl/gcs_rr_arbiter.sv | 38 +++
 rtl/gray_conv_scheduler.sv | 140 ++++++++++++++
 tb/tb_gray_conv_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types, default sizes and the reference Gray function for gray_conv_scheduler.
package gray_conv_pkg;

  localparam int unsigned GCS_NREQ = 4;
  localparam int unsigned GCS_W    = 4;
  // Widest operand bin2gray accepts; narrower operands are zero-extended by the caller.
  localparam int unsigned GCS_MAXW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } gcs_state_t;

  // Binary-to-Gray of a zero-extended operand; truncate the result back to the operand width.
  function automatic logic [GCS_MAXW-1:0] bin2gray(input logic [GCS_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gcs_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, wrapping to 0.
module gcs_rr_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned NREQ = GCS_NREQ,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner
);

  logic found;

  // Two passes: indices >= rr_ptr first, then the wrapped indices below rr_ptr.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (i >= 32'(rr_ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winner   = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (i < 32'(rr_ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winner   = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one external binary-to-Gray converter among NREQ requesters.
// Optional sticky converter self-check enabled by GRAY_CONV_SCHEDULER_CHECK_EN (adds conv_err).
module gray_conv_scheduler
  import gray_conv_pkg::*;
#(
  parameter int unsigned NREQ = GCS_NREQ,
  parameter int unsigned W    = GCS_W,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      conv_bin,
  input  logic [W-1:0]      conv_gray,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_gray
`ifdef GRAY_CONV_SCHEDULER_CHECK_EN
  ,
  output logic              conv_err
`endif
);

  gcs_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr, rr_ptr_d;
  logic [W-1:0]     conv_bin_d;
  logic [IDW-1:0]   rsp_id_d;
  logic [W-1:0]     rsp_gray_d;
  logic             rsp_valid_d;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   winner;
  logic             arb_en;
  logic [W-1:0]     win_data;

  // Grants only exist in IDLE and never while reset is held.
  assign arb_en    = (state_q == IDLE) && !rst;
  assign req_ready = grant;

  gcs_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .en     (arb_en),
    .grant  (grant),
    .winner (winner)
  );

  // Operand of the granted requester, selected by the one-hot grant.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_data = win_data | req_data[i*W +: W];
      end
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr;
    conv_bin_d  = conv_bin;
    rsp_id_d    = rsp_id;
    rsp_gray_d  = rsp_gray;
    rsp_valid_d = rsp_valid;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          conv_bin_d = win_data;
          rsp_id_d   = winner;
          rr_ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
          state_d    = CONV;
        end
      end
      CONV: begin
        rsp_gray_d  = conv_gray;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      conv_bin  <= '0;
      rsp_id    <= '0;
      rsp_gray  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      conv_bin  <= conv_bin_d;
      rsp_id    <= rsp_id_d;
      rsp_gray  <= rsp_gray_d;
      rsp_valid <= rsp_valid_d;
    end
  end

`ifdef GRAY_CONV_SCHEDULER_CHECK_EN
  logic [W-1:0] gray_ref;
  logic         conv_err_d;

  // Independent Gray reference, compared against the converter at the capture edge.
  always_comb begin
    gray_ref   = W'(bin2gray(GCS_MAXW'(conv_bin)));
    conv_err_d = conv_err;
    if ((state_q == CONV) && (conv_gray != gray_ref)) begin
      conv_err_d = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_err <= 1'b0;
    end else begin
      conv_err <= conv_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Randomized and directed bench for gray_conv_scheduler with a transaction-level reference model.
module tb_gray_conv_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      conv_bin;
  logic [W-1:0]      conv_gray;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_gray;
  logic              fault;
`ifdef GRAY_CONV_SCHEDULER_CHECK_EN
  logic              conv_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: busy phase (0 idle, 1 converting, 2 responding) plus held values.
  int m_phase, m_ptr, m_id, m_bin, m_gray, m_err;

  gray_conv_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .conv_bin  (conv_bin),
    .conv_gray (conv_gray),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gray  (rsp_gray)
`ifdef GRAY_CONV_SCHEDULER_CHECK_EN
    ,
    .conv_err  (conv_err)
`endif
  );

  // External converter; when fault is set, the result for operand 0011 is corrupted.
  assign conv_gray = (fault && conv_bin == 4'b0011) ? 4'b0000 : (conv_bin ^ (conv_bin >> 1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_bin = 0; m_gray = 0; m_err = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_conv_bin",  32'(conv_bin),  32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_gray",  32'(rsp_gray),  32'd0);
`ifdef GRAY_CONV_SCHEDULER_CHECK_EN
    chk("rst_conv_err",  32'(conv_err),  32'd0);
`endif
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic step();
    int exp_rdy, win, idx, n_phase, n_ptr, n_id, n_bin, n_gray, n_err_flag, cap;
    @(negedge clk);
    exp_rdy = 0;
    win = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        idx = (m_ptr + k) % int'(NREQ);
        if (win < 0 && req_valid[idx]) win = idx;
      end
      if (win >= 0) exp_rdy = 1 << win;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    chk("conv_bin",  32'(conv_bin),  32'(m_bin));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_gray",  32'(rsp_gray),  32'(m_gray));
`ifdef GRAY_CONV_SCHEDULER_CHECK_EN
    chk("conv_err",  32'(conv_err),  32'(m_err));
`endif
    n_phase = m_phase; n_ptr = m_ptr; n_id = m_id; n_bin = m_bin;
    n_gray = m_gray; n_err_flag = m_err;
    case (m_phase)
      0: if (win >= 0) begin
        n_bin   = int'((req_data >> (win * int'(W))) & 16'hF);
        n_id    = win;
        n_ptr   = (win + 1) % int'(NREQ);
        n_phase = 1;
      end
      1: begin
        cap = (fault && m_bin == 3) ? 0 : gray_of(m_bin);
        n_gray = cap;
        if (cap != gray_of(m_bin)) n_err_flag = 1;
        n_phase = 2;
      end
      default: if (rsp_ready) n_phase = 0;
    endcase
    @(posedge clk);
    #1;
    m_phase = n_phase; m_ptr = n_ptr; m_id = n_id; m_bin = n_bin;
    m_gray = n_gray; m_err = n_err_flag;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    rst = 1'b1;
    #2;
    chk_reset_outputs();
    model_reset();
    req_valid = '0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; fault = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;

    // Single request from requester 1 with operand 0011.
    req_valid = 4'b0010; req_data = 16'h0030;
    step();
    req_valid = '0;
    repeat (3) step();

    // Backpressure on operand 1001 from requester 3.
    req_valid = 4'b1000; req_data = 16'h9000; rsp_ready = 1'b0;
    step();
    req_valid = 4'b1111;
    repeat (6) step();
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (2) step();

    // All four requesters valid with 0,5,10,15; grants must rotate and return to 0.
    req_valid = 4'b1111; req_data = 16'hFA50;
    repeat (13) step();
    req_valid = '0;
    repeat (3) step();

    // Reset while converting; the in-flight request vanishes and requester 0 wins next.
    req_valid = 4'b0100; req_data = 16'h0700;
    step();
    async_reset();
    req_valid = 4'b1111;
    step();
    req_valid = '0;
    repeat (3) step();

    // Requester 2 sweeps every operand.
    for (int v = 0; v < 16; v++) begin
      req_valid = 4'b0100; req_data = 16'(v << 8);
      step();
      req_valid = '0;
      repeat (2) step();
    end

    // Faulty converter result for operand 0011, then clear with reset.
    fault = 1'b1;
    req_valid = 4'b0001; req_data = 16'h0003;
    step();
    req_valid = '0;
    repeat (5) step();
    fault = 1'b0;
    req_valid = 4'b0010; req_data = 16'h0050;
    step();
    req_valid = '0;
    repeat (3) step();
    async_reset();
    step();

    // Random traffic with random backpressure and valid churn.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_data  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
